if_id_skid: RTL and testbench

Pipeline boundary between the instruction-fetch stage and the decode stage. Captures the fetched `{PC, pc4, inst}` beat each cycle and presents it to decode with a valid bit. A two-entry skid buffer lets decode back-pressure without a combinational ready path into the PC register. Branch/jump redirects are applied here as a synchronous flush that turns in-flight beats into NOP bubbles.

---
 rtl/mips_pkg.sv | 11 +
 rtl/if_id_skid_pipe_slot.sv | 30 +++
 rtl/if_id_skid.sv | 71 +++++++
 tb/tb_if_id_skid.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, NOP encoding and the IF/ID beat payload type.
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
  } ifid_beat_t;
  localparam ifid_beat_t NOP_BEAT = '{pc: '0, pc4: '0, inst: NOP_INST};
endpackage

// File: rtl/if_id_skid_pipe_slot.sv
// pipe_slot: one IF/ID payload register plus valid bit.
// Clear (to a NOP bubble) has priority over load; otherwise the slot holds.
module pipe_slot
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_clear,
  input  ifid_beat_t i_d,
  output logic       o_valid,
  output ifid_beat_t o_q
);
  logic       r_valid;
  ifid_beat_t r_beat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_beat  <= NOP_BEAT;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_beat  <= NOP_BEAT;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_d;
    end
  end
  assign o_valid = r_valid;
  assign o_q     = r_beat;
endmodule

// File: rtl/if_id_skid.sv
// if_id_skid: IF->ID boundary with a two-entry skid buffer and synchronous flush.
// Optional IFID_PERF_EN adds fetch and bubble counters.
module if_id_skid
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [WIDTH-1:0] if_pc,
  input  logic [WIDTH-1:0] if_pc4,
  input  logic [WIDTH-1:0] if_inst,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_pc4,
`ifdef IFID_PERF_EN
  output logic [WIDTH-1:0] id_inst,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_bubble_cnt
`else
  output logic [WIDTH-1:0] id_inst
`endif
);
  ifid_beat_t w_in, w_m, w_s, w_m_d;
  logic w_m_valid, w_s_valid, w_up, w_dn;
  logic w_m_from_s, w_m_from_in, w_m_load, w_m_clear, w_s_load, w_s_clear;
  assign w_in = '{pc: if_pc, pc4: if_pc4, inst: if_inst};
  assign if_ready = !w_s_valid;
  assign w_up = if_valid && if_ready;
  assign w_dn = w_m_valid && id_ready;
  always_comb begin
    w_m_from_s  = w_m_valid && w_s_valid && w_dn;
    w_m_from_in = w_up && (!w_m_valid || w_dn);
    w_m_load    = w_m_from_s || w_m_from_in;
    w_m_d       = w_m_from_s ? w_s : w_in;
    w_m_clear   = flush || (w_dn && !w_m_load);
    w_s_load    = w_up && w_m_valid && !w_dn;
    // a stray skid entry with an empty main (01) is dropped, behaving as EMPTY
    w_s_clear   = flush || w_m_from_s || (w_s_valid && !w_m_valid);
  end
  pipe_slot u_main (
    .clk(clk), .rst(clr), .i_load(w_m_load), .i_clear(w_m_clear),
    .i_d(w_m_d), .o_valid(w_m_valid), .o_q(w_m)
  );
  pipe_slot u_skid (
    .clk(clk), .rst(clr), .i_load(w_s_load), .i_clear(w_s_clear),
    .i_d(w_in), .o_valid(w_s_valid), .o_q(w_s)
  );
  assign id_valid = w_m_valid;
  assign id_pc    = w_m.pc;
  assign id_pc4   = w_m.pc4;
  assign id_inst  = w_m_valid ? w_m.inst : NOP_INST;
`ifdef IFID_PERF_EN
  logic [31:0] r_fetch_cnt, r_bubble_cnt;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_fetch_cnt  <= r_fetch_cnt + {31'd0, w_dn};
      r_bubble_cnt <= r_bubble_cnt + {31'd0, id_ready && !w_m_valid};
    end
  end
  assign perf_fetch_cnt  = r_fetch_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid: directed self-checking bench for if_id_skid.
// Perf-counter checks are compiled only with IFID_PERF_EN.
module tb_if_id_skid;
  logic        clk = 1'b0;
  logic        clr, if_valid, flush, id_ready;
  logic        if_ready, id_valid;
  logic [31:0] if_pc, if_pc4, if_inst, id_pc, id_pc4, id_inst;
`ifdef IFID_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif
  int n_run = 0;
  int n_fail = 0;

  if_id_skid #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_pc4(id_pc4),
`ifdef IFID_PERF_EN
    .id_inst(id_inst), .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`else
    .id_inst(id_inst)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_pc4   = pc + 32'd4;
    if_inst  = inst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    flush = 1'b0;
    id_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if ({id_valid, if_ready, id_inst, id_pc, id_pc4} !== {1'b0, 1'b1, 96'h0}) begin
      n_fail++;
      $display("FAIL reset_init: got v=%b rdy=%b inst=%h pc=%h want v=0 rdy=1 zeros", id_valid, if_ready, id_inst, id_pc);
    end
`ifdef IFID_PERF_EN
    n_run++;
    if ({perf_fetch_cnt, perf_bubble_cnt} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetch_cnt, perf_bubble_cnt);
    end
`endif
    id_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hAAAA_0001);
    tick();
    drive(1'b1, 32'h104, 32'hAAAA_0002);
    tick();
    n_run++;
    if ({id_valid, if_ready, id_pc} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL reset_full_setup: got v=%b rdy=%b pc=%h want v=1 rdy=0 pc=100", id_valid, if_ready, id_pc);
    end
    #2 clr = 1'b1;
    #1;
    n_run++;
    if ({id_valid, if_ready, id_inst, id_pc, id_pc4} !== {1'b0, 1'b1, 96'h0}) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b rdy=%b inst=%h pc=%h pc4=%h want v=1'b0 rdy=1 zeros", id_valid, if_ready, id_inst, id_pc, id_pc4);
    end
    #2 clr = 1'b0;
    id_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h2001_0005);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_run++;
    if ({id_valid, id_pc, id_pc4, id_inst} !== {1'b1, 32'h0, 32'h4, 32'h2001_0005}) begin
      n_fail++;
      $display("FAIL reset_first_beat: got v=%b pc=%h pc4=%h inst=%h want v=1 pc=0 pc4=4 inst=20010005", id_valid, id_pc, id_pc4, id_inst);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i));
      tick();
      n_run++;
      if ({id_valid, if_ready, id_pc, id_pc4, id_inst} !== {1'b1, 1'b1, 32'(i * 4), 32'(i * 4 + 4), 32'h1000_0000 + 32'(i)}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b rdy=%b pc=%h inst=%h want v=1 rdy=1 pc=%h inst=%h", i, id_valid, if_ready, id_pc, id_inst, i * 4, 32'h1000_0000 + i);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    n_run++;
    if ({id_valid, id_inst} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL stream_tail: got v=%b inst=%h want v=0 inst=0", id_valid, id_inst);
    end
`ifdef IFID_PERF_EN
    n_run++;
    if (perf_fetch_cnt !== 32'd8) begin
      n_fail++;
      $display("FAIL stream_fetch_cnt: got %0d want 8", perf_fetch_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 32'h200, 32'hB000_0000);
    tick();
    drive(1'b1, 32'h204, 32'hB000_0001);
    id_ready = 1'b0;
    tick();
    drive(1'b1, 32'h208, 32'hB000_0002);
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if ({id_valid, if_ready, id_pc, id_pc4, id_inst} !== {1'b1, 1'b0, 32'h200, 32'h204, 32'hB000_0000}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b rdy=%b pc=%h inst=%h want v=1 rdy=0 pc=200 inst=b0000000", i, id_valid, if_ready, id_pc, id_inst);
      end
      if (i < 2) tick();
    end
    id_ready = 1'b1;
    tick();
    n_run++;
    if ({id_valid, if_ready, id_pc, id_inst} !== {1'b1, 1'b1, 32'h204, 32'hB000_0001}) begin
      n_fail++;
      $display("FAIL stall_drain1: got v=%b rdy=%b pc=%h inst=%h want v=1 rdy=1 pc=204 inst=b0000001", id_valid, if_ready, id_pc, id_inst);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_run++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h208, 32'hB000_0002}) begin
      n_fail++;
      $display("FAIL stall_drain2: got v=%b pc=%h inst=%h want v=1 pc=208 inst=b0000002", id_valid, id_pc, id_inst);
    end
    tick();
    n_run++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_empty: got v=%b want 0", id_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    id_ready = 1'b0;
    drive(1'b1, 32'h300, 32'hC000_0000);
    tick();
    drive(1'b1, 32'h304, 32'hC000_0001);
    tick();
    drive(1'b1, 32'h308, 32'hC000_0002);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    n_run++;
    if ({id_valid, id_inst, if_ready, id_pc} !== {1'b0, 32'h0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_clear: got v=%b inst=%h rdy=%b pc=%h want v=0 inst=0 rdy=1 pc=0", id_valid, id_inst, if_ready, id_pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if (id_valid !== 1'b0 || id_pc === 32'h300 || id_pc === 32'h304 || id_pc === 32'h308) begin
        n_fail++;
        $display("FAIL flush_no_replay[%0d]: got v=%b pc=%h want v=0 and no flushed pc", i, id_valid, id_pc);
      end
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    drive(1'b1, 32'h30, 32'hD000_0000);
    tick();
    drive(1'b1, 32'h34, 32'hD000_0001);
    flush = 1'b1;
    id_ready = 1'b0;
    tick();
    flush = 1'b0;
    n_run++;
    if ({id_valid, if_ready, id_inst} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_stall_empty: got v=%b rdy=%b inst=%h want v=0 rdy=1 inst=0", id_valid, if_ready, id_inst);
    end
    id_ready = 1'b1;
    drive(1'b1, 32'h40, 32'hD000_0040);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_run++;
    if ({id_valid, id_pc, id_pc4, id_inst} !== {1'b1, 32'h40, 32'h44, 32'hD000_0040}) begin
      n_fail++;
      $display("FAIL flush_stall_next: got v=%b pc=%h inst=%h want v=1 pc=40 inst=d0000040", id_valid, id_pc, id_inst);
    end
    tick();
    n_run++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall_alone: got v=%b want 0", id_valid);
    end
  endtask

`ifdef IFID_PERF_EN
  task automatic test_perf_wrap();
    do_reset();
    force dut.r_bubble_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_bubble_cnt;
    tick();
    n_run++;
    if (perf_bubble_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL perf_bubble_wrap: got %h want 00000000", perf_bubble_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_stall();
`ifdef IFID_PERF_EN
    test_perf_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
